rsa_operand_fetch: RTL and testbench

Sequencer that sits directly downstream of the 256x32 input SRAM of the RSA datapath. On `start` it reads the 192 operand words (message, exponent key, modulus; 64 words each) from the SRAM's registered-address read port and presents them as a valid/ready word stream tagged with region and index. It absorbs the SRAM's one-cycle read latency and downstream backpressure with a 2-entry buffer. At full rate it sustains one word per cycle.

---
 rtl/rsa_pkg.sv | 35 +++
 rtl/rsa_fetch_skid_fifo.sv | 54 +++++
 rtl/rsa_operand_fetch.sv | 140 ++++++++++++++
 tb/tb_rsa_operand_fetch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA operand datapath: region selects,
// operand geometry, SRAM base addresses and the operand-fetch FSM states.
package rsa_pkg;

   localparam int unsigned RSA_WORDS    = 64;
   localparam int unsigned RSA_WORD_W   = 32;
   localparam logic [7:0]  RSA_MSG_BASE = 8'd0;
   localparam logic [7:0]  RSA_KEY_BASE = 8'd64;
   localparam logic [7:0]  RSA_MOD_BASE = 8'd128;

   typedef enum logic [1:0] {
      RSA_SEL_MSG = 2'd0,
      RSA_SEL_KEY = 2'd1,
      RSA_SEL_MOD = 2'd2
   } rsa_sel_e;

   typedef enum logic [1:0] {
      FETCH_IDLE,
      FETCH_FETCH,
      FETCH_DRAIN,
      FETCH_DONE
   } rsa_fetch_state_e;

   typedef struct packed {
      rsa_sel_e   sel;
      logic [5:0] idx;
      logic       last;
   } rsa_tag_t;

   typedef struct packed {
      logic [RSA_WORD_W-1:0] data;
      rsa_tag_t              tag;
   } rsa_word_t;

endpackage

// File: rtl/rsa_fetch_skid_fifo.sv
// Two-entry word buffer (data + region/index/last tag) that absorbs the SRAM
// read latency and downstream backpressure for the operand fetcher.
module rsa_fetch_skid_fifo
   import rsa_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic       pop_i,
   input  rsa_word_t  push_word_i,
   output logic [1:0] count_o,
   output rsa_word_t  head_o
);

   rsa_word_t  mem_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;
   logic [1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (push_i && !pop_i) begin
         count_d = count_q + 2'd1;
      end else if (pop_i && !push_i) begin
         count_d = count_q - 2'd1;
      end
   end

   // Storage is cleared on reset so the head reads as zero afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_word_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rsa_operand_fetch.sv
// Streams message, key and modulus words out of the input SRAM as a tagged
// valid/ready stream. Define RSA_FETCH_MSB_FIRST_EN for descending in-region order.
module rsa_operand_fetch
   import rsa_pkg::*;
#(
   parameter int unsigned WORDS    = RSA_WORDS,
   parameter logic [7:0]  MSG_BASE = RSA_MSG_BASE,
   parameter logic [7:0]  KEY_BASE = RSA_KEY_BASE,
   parameter logic [7:0]  MOD_BASE = RSA_MOD_BASE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        sram_en,
   output logic [7:0]  sram_addr,
   input  logic [31:0] sram_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [1:0]  out_sel,
   output logic [5:0]  out_idx,
   output logic        out_last,
   output logic        busy,
   output logic        done
);

   localparam logic [5:0] POS_MAX = 6'(WORDS - 1);

   rsa_fetch_state_e state_q, state_d;
   rsa_sel_e         sel_q, sel_d;
   logic [5:0]       pos_q, pos_d;
   logic             inflight_q;
   rsa_tag_t         tag_q;
   rsa_tag_t         tag_cur;
   logic [7:0]       base;
   logic [1:0]       count;
   rsa_word_t        head;
   rsa_word_t        push_word;
   logic             issue;
   logic             pop;

   rsa_fetch_skid_fifo u_skid (
      .clk         (clk),
      .rst         (rst),
      .push_i      (inflight_q),
      .pop_i       (pop),
      .push_word_i (push_word),
      .count_o     (count),
      .head_o      (head)
   );

   assign out_valid = (count != 2'd0);
   assign pop       = out_valid && out_ready;
   assign out_data  = head.data;
   assign out_sel   = head.tag.sel;
   assign out_idx   = head.tag.idx;
   assign out_last  = head.tag.last;
   assign busy      = (state_q != FETCH_IDLE);
   assign done      = (state_q == FETCH_DONE);
   assign push_word = {sram_data, tag_q};

   // Credit: buffered + inflight words after this cycle's pop must leave room.
   assign issue     = (state_q == FETCH_FETCH) &&
                      (({1'b0, count} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
   assign sram_en   = issue;
   assign sram_addr = issue ? (base + {2'b0, tag_cur.idx}) : '0;

   always_comb begin
      tag_cur.sel  = sel_q;
`ifdef RSA_FETCH_MSB_FIRST_EN
      tag_cur.idx  = POS_MAX - pos_q;
`else
      tag_cur.idx  = pos_q;
`endif
      tag_cur.last = (sel_q == RSA_SEL_MOD) && (pos_q == POS_MAX);
      case (sel_q)
         RSA_SEL_MSG: base = MSG_BASE;
         RSA_SEL_KEY: base = KEY_BASE;
         default:     base = MOD_BASE;
      endcase
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      pos_d   = pos_q;
      case (state_q)
         FETCH_IDLE: begin
            if (start) begin
               state_d = FETCH_FETCH;
               sel_d   = RSA_SEL_MSG;
               pos_d   = '0;
            end
         end
         FETCH_FETCH: begin
            if (issue) begin
               if (pos_q == POS_MAX) begin
                  pos_d = '0;
                  case (sel_q)
                     RSA_SEL_MSG: sel_d = RSA_SEL_KEY;
                     RSA_SEL_KEY: sel_d = RSA_SEL_MOD;
                     default: begin
                        sel_d   = RSA_SEL_MSG;
                        state_d = FETCH_DRAIN;
                     end
                  endcase
               end else begin
                  pos_d = pos_q + 6'd1;
               end
            end
         end
         FETCH_DRAIN: begin
            if (pop && head.tag.last) begin
               state_d = FETCH_DONE;
            end
         end
         FETCH_DONE:  state_d = FETCH_IDLE;
         default:     state_d = FETCH_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FETCH_IDLE;
         sel_q      <= RSA_SEL_MSG;
         pos_q      <= '0;
         inflight_q <= 1'b0;
         tag_q      <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         pos_q      <= pos_d;
         inflight_q <= issue;
         if (issue) begin
            tag_q <= tag_cur;
         end
      end
   end

endmodule

// File: tb/tb_rsa_operand_fetch.sv
// Directed bench for rsa_operand_fetch: checks every cycle against an ordered
// stream model; follows RSA_FETCH_MSB_FIRST_EN for the descending build.
module tb_rsa_operand_fetch;

   localparam int N = 192;

`ifdef RSA_FETCH_MSB_FIRST_EN
   localparam bit MSB_FIRST = 1'b1;
`else
   localparam bit MSB_FIRST = 1'b0;
`endif

   localparam logic [31:0] FIRST_WORD = MSB_FIRST ? 32'hA500003F : 32'hA5000000;
   localparam logic [31:0] KEY_FIRST  = MSB_FIRST ? 32'hA500007F : 32'hA5000040;
   localparam logic [31:0] LAST_WORD  = MSB_FIRST ? 32'hA5000080 : 32'hA50000BF;
   localparam logic [31:0] LAST_IDX   = MSB_FIRST ? 32'd0 : 32'd63;
   localparam logic [31:0] FIRST_ADDR = MSB_FIRST ? 32'd63 : 32'd0;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sram_en;
   logic [7:0]  sram_addr;
   logic [31:0] sram_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  out_sel;
   logic [5:0]  out_idx;
   logic        out_last;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   rsa_operand_fetch dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sram_en   (sram_en),
      .sram_addr (sram_addr),
      .sram_data (sram_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   logic [31:0] ram [256];
   always @(posedge clk) begin
      if (sram_en) sram_data <= ram[sram_addr];
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int xfer_n, iss_n, done_n, first_valid, last_cyc, done_cyc, lows;
   logic        prev_stall, prev_last;
   logic [40:0] prev_word;

   logic [31:0] exp_data [N];
   logic [1:0]  exp_sel  [N];
   logic [5:0]  exp_idx  [N];
   logic        exp_last [N];
   logic [7:0]  exp_addr [N];
   logic [31:0] got_data [N];
   logic [1:0]  got_sel  [N];
   logic [5:0]  got_idx  [N];
   logic        got_last [N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
      end
   endtask

   task automatic reset_model();
      xfer_n      = 0;
      iss_n       = 0;
      done_n      = 0;
      first_valid = -1;
      last_cyc    = -1;
      done_cyc    = -1;
      prev_stall  = 1'b0;
      prev_last   = 1'b0;
      prev_word   = '0;
   endtask

   task automatic check_cycle();
      logic xfer;
      if (rst) begin
         reset_model();
         return;
      end
      xfer = out_valid && out_ready;
      chk1("occupancy_le_2", (iss_n - xfer_n) <= 2, 1'b1);
      if (prev_stall) begin
         chk1("stall_valid", out_valid, 1'b1);
         chk("stall_data", out_data, prev_word[40:9]);
         chk("stall_tag", 32'({out_sel, out_idx, out_last}), 32'(prev_word[8:0]));
      end
      if (xfer) begin
         chk1("xfer_in_range", xfer_n < N, 1'b1);
         if (xfer_n < N) begin
            chk("xfer_data", out_data, exp_data[xfer_n]);
            chk("xfer_sel", 32'(out_sel), 32'(exp_sel[xfer_n]));
            chk("xfer_idx", 32'(out_idx), 32'(exp_idx[xfer_n]));
            chk1("xfer_last", out_last, exp_last[xfer_n]);
            got_data[xfer_n] = out_data;
            got_sel[xfer_n]  = out_sel;
            got_idx[xfer_n]  = out_idx;
            got_last[xfer_n] = out_last;
            if (out_last) last_cyc = cyc;
            xfer_n++;
         end
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      chk1("done_after_last", done, prev_last);
      if (done) begin
         done_n++;
         done_cyc = cyc;
         chk1("busy_at_done", busy, 1'b1);
      end
      if (sram_en) begin
         chk1("busy_when_reading", busy, 1'b1);
         chk1("read_in_range", iss_n < N, 1'b1);
         if (iss_n < N) chk("read_addr", 32'(sram_addr), 32'(exp_addr[iss_n]));
         iss_n++;
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_data, out_sel, out_idx, out_last};
      prev_last  = xfer && out_last;
   endtask

   task automatic step();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk1({tag, "_sram_en"}, sram_en, 1'b0);
      chk({tag, "_sram_addr"}, 32'(sram_addr), 32'd0);
      chk1({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_out_data"}, out_data, 32'd0);
      chk({tag, "_out_sel"}, 32'(out_sel), 32'd0);
      chk({tag, "_out_idx"}, 32'(out_idx), 32'd0);
      chk1({tag, "_out_last"}, out_last, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_done"}, done, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 + 32'(i);
      // Stream order: regions msg/key/mod at base region*64, index per build order.
      for (int k = 0; k < N; k++) begin
         int r, p, ix;
         r  = k / 64;
         p  = k % 64;
         ix = MSB_FIRST ? (63 - p) : p;
         exp_sel[k]  = 2'(r);
         exp_idx[k]  = 6'(ix);
         exp_addr[k] = 8'(r * 64 + ix);
         exp_data[k] = 32'hA500_0000 + 32'(r * 64 + ix);
         exp_last[k] = (k == N - 1);
      end

      // Reset held 3 cycles with start high.
      rst       = 1'b1;
      start     = 1'b1;
      out_ready = 1'b1;
      reset_model();
      repeat (3) step();
      chk_reset_outputs("rst");
      rst   = 1'b0;
      start = 1'b0;
      step();
      chk1("start_with_rst_ignored", busy, 1'b0);

      // Full rate from cycle 0.
      reset_model();
      cyc   = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk1("c1_busy", busy, 1'b1);
      chk1("c1_sram_en", sram_en, 1'b1);
      chk("c1_addr", 32'(sram_addr), FIRST_ADDR);
      while (cyc < 196) step();
      chk("full_first_valid_cyc", first_valid, 32'd3);
      chk("full_last_cyc", last_cyc, 32'd194);
      chk("full_done_cyc", done_cyc, 32'd195);
      chk("full_xfers", xfer_n, 32'd192);
      chk("full_done_pulses", done_n, 32'd1);
      chk("full_first_word", got_data[0], FIRST_WORD);
      chk("full_key_first", got_data[64], KEY_FIRST);
      chk("full_last_word", got_data[191], LAST_WORD);
      chk("full_last_sel", 32'(got_sel[191]), 32'd2);
      chk("full_last_idx", 32'(got_idx[191]), LAST_IDX);
      chk1("full_last_flag", got_last[191], 1'b1);
      chk1("idle_at_196", busy, 1'b0);

      // Backpressure: start accepted in cycle 196, stall 10 cycles at word 5, then random.
      begin
         bit stalled;
         int stall_left;
         stalled    = 1'b0;
         stall_left = 0;
         lows       = 0;
         reset_model();
         cyc   = 0;
         start = 1'b1;
         step();
         start = 1'b0;
         chk1("restart_busy", busy, 1'b1);
         for (int i = 0; i < 3000 && done_n == 0; i++) begin
            if (!stalled && xfer_n == 5) begin
               stalled    = 1'b1;
               stall_left = 10;
            end
            if (stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
            end else if (stalled) begin
               out_ready = 1'($urandom_range(0, 1));
            end else begin
               out_ready = 1'b1;
            end
            if (!out_ready) lows++;
            step();
         end
         out_ready = 1'b1;
         step();
         chk("bp_xfers", xfer_n, 32'd192);
         chk("bp_reads", iss_n, 32'd192);
         chk("bp_done_pulses", done_n, 32'd1);
         chk1("bp_latency_bound", (done_cyc <= 195 + lows) && (done_cyc >= 195), 1'b1);
      end

      // Start pulses while busy are ignored.
      reset_model();
      cyc = 0;
      for (int i = 0; i < 260; i++) begin
         start = (cyc == 0) || (cyc == 20) || (cyc == 100);
         step();
      end
      start = 1'b0;
      chk("busy_start_xfers", xfer_n, 32'd192);
      chk("busy_start_reads", iss_n, 32'd192);
      chk("busy_start_done_pulses", done_n, 32'd1);
      chk("busy_start_done_cyc", done_cyc, 32'd195);

      // Reset after transfer 70, then a clean restart.
      reset_model();
      cyc   = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 400 && xfer_n < 70; i++) step();
      chk("mid_reached_70", xfer_n, 32'd70);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_reset_outputs("mid_rst");
      reset_model();
      cyc   = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 400 && done_n == 0; i++) step();
      step();
      chk("mid_first_word", got_data[0], FIRST_WORD);
      chk("mid_xfers", xfer_n, 32'd192);
      chk("mid_done_pulses", done_n, 32'd1);
      chk("mid_done_cyc", done_cyc, 32'd195);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
